// File: rtl/cryptoveril_pipe.sv
// ---------------------------------------------------------------------------
// cryptoveril_pipe
//   Parametrised keyed round pipeline. STAGES identical round stages carry a
//   valid/ready stream at one beat per cycle. Every beat travels with its own
//   key and mode, so encrypt and decrypt beats may be freely interleaved.
//
//   Round i: rk_i = in_key replicated to DATA_W bits, rotated left by i
//            r_i  = (key + i) mod DATA_W,  c_i = i + 1
//   Encrypt stage j applies round i = j:          x = rotl(x ^ rk, r) + c
//   Decrypt stage j applies round i = STAGES-1-j: x = rotr(x - c, r) ^ rk
//
//   Optional build macro: CRYPTO_STATS_EN adds stat_beats / stat_stall.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   in_valid/ready  input handshake; in_data, in_key, in_dec sampled on accept
//   out_valid/ready output handshake; out_data result word
//   stat_beats      (CRYPTO_STATS_EN) completed output beats, wraps at 16 bits
//   stat_stall      (CRYPTO_STATS_EN) cycles with out_valid & !out_ready
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. A producer holding valid keeps its payload stable
// until it is taken; ready may depend combinationally on the downstream
// ready (in_ready is the end of a ready chain starting at out_ready).
// ---------------------------------------------------------------------------
module cryptoveril_pipe #(
  parameter int DATA_W = 16,
  parameter int KEY_W  = 5,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  in_key,
  input  logic              in_dec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef CRYPTO_STATS_EN
  ,
  output logic [15:0]       stat_beats,
  output logic [15:0]       stat_stall
`endif
);

  // Enough key copies to cover the data width.
  localparam int REP = (DATA_W + KEY_W - 1) / KEY_W;

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int r);
    logic [2*DATA_W-1:0] t;
    t = {x, x} << r;
    return t[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int r);
    logic [2*DATA_W-1:0] t;
    t = {x, x} >> r;
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] round_fn(input logic [DATA_W-1:0] x,
                                                 input logic [KEY_W-1:0]  key,
                                                 input logic              dec,
                                                 input int                i);
    logic [REP*KEY_W-1:0] rep;
    logic [DATA_W-1:0]    rk;
    logic [DATA_W-1:0]    c;
    int                   r;
    rep = {REP{key}};
    rk  = rotl(rep[DATA_W-1:0], i % DATA_W);
    r   = (int'(key) + i) % DATA_W;
    c   = DATA_W'(i + 1);
    if (dec) round_fn = rotr(x - c, r) ^ rk;
    else     round_fn = rotl(x ^ rk, r) + c;
  endfunction

  // Stage registers
  logic [STAGES-1:0]             v;
  logic [STAGES-1:0]             m;
  logic [STAGES-1:0][DATA_W-1:0] d;
  logic [STAGES-1:0][KEY_W-1:0]  k;

  // Per-stage source (previous stage or input port) and next data
  logic [STAGES-1:0]             src_v;
  logic [STAGES-1:0]             src_m;
  logic [STAGES-1:0][DATA_W-1:0] src_d;
  logic [STAGES-1:0][KEY_W-1:0]  src_k;
  logic [STAGES-1:0][DATA_W-1:0] nxt_d;

  // rdy[s]: stage s loads this cycle (empty, or its content moves on)
  logic [STAGES-1:0]             rdy;

  for (genvar s = 0; s < STAGES; s++) begin : g_src
    if (s == 0) begin : g_head
      assign src_v[s] = in_valid;
      assign src_m[s] = in_dec;
      assign src_d[s] = in_data;
      assign src_k[s] = in_key;
    end else begin : g_body
      assign src_v[s] = v[s-1];
      assign src_m[s] = m[s-1];
      assign src_d[s] = d[s-1];
      assign src_k[s] = k[s-1];
    end
  end

  // Ready chain from the output back to the input; a full stage can still
  // load when its content is taken in the same cycle.
  always_comb begin
    logic down;
    rdy  = '0;
    down = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy[s] = !v[s] || down;
      down   = rdy[s];
    end
  end

  // Decrypt runs the rounds in reverse order across the physical stages.
  always_comb begin
    nxt_d = '0;
    for (int s = 0; s < STAGES; s++) begin
      nxt_d[s] = round_fn(src_d[s], src_k[s], src_m[s], src_m[s] ? (STAGES - 1 - s) : s);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      m <= '0;
      d <= '0;
      k <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) begin
          v[s] <= src_v[s];
          m[s] <= src_m[s];
          d[s] <= nxt_d[s];
          k[s] <= src_k[s];
        end
      end
    end
  end

  // Held low during reset so the framer cannot push into a clearing pipe.
  assign in_ready  = rst && rdy[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // The last stage's key and mode travel with the beat but have no consumer.
  logic unused_last;
  assign unused_last = ^{k[STAGES-1], m[STAGES-1]};

`ifdef CRYPTO_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (out_valid && out_ready)  stat_beats <= stat_beats + 16'd1;
      if (out_valid && !out_ready) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cryptoveril_pipe.sv
// ---------------------------------------------------------------------------
// tb_cryptoveril_pipe
//   Directed bench for cryptoveril_pipe (DATA_W=16, KEY_W=5, STAGES=3).
//   Inputs are driven on the falling edge; outputs are sampled 1 time unit
//   later. Accepted beats push their expected result into exp_q; every
//   output beat taken pops and compares against it.
// ---------------------------------------------------------------------------
module tb_cryptoveril_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_key;
  logic        in_dec;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef CRYPTO_STATS_EN
  logic [15:0] stat_beats;
  logic [15:0] stat_stall;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          n_out  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_exp;
  logic        s_in_ready, s_out_valid, s_acc, s_emit;
  logic [15:0] s_out_data;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;

  cryptoveril_pipe #(.DATA_W(16), .KEY_W(5), .STAGES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_dec    (in_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef CRYPTO_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_stall(stat_stall)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] rol16(input logic [15:0] x, input int r);
    rol16 = (x << r) | (x >> (16 - r));
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] x, input int r);
    ror16 = (x >> r) | (x << (16 - r));
  endfunction

  function automatic logic [15:0] model(input logic [15:0] x, input logic [4:0] key, input logic dec);
    logic [15:0] y, base, rk, c;
    int          i, r;
    y = x;
    for (int b = 0; b < 16; b++) base[b] = key[b % 5];
    for (int step = 0; step < 3; step++) begin
      i  = dec ? (2 - step) : step;
      rk = rol16(base, i);
      r  = (int'(key) + i) % 16;
      c  = 16'(i + 1);
      if (dec) y = ror16(y - c, r) ^ rk;
      else     y = rol16(y ^ rk, r) + c;
    end
    return y;
  endfunction

  // ---------------- driver / scoreboard ----------------
  // One clock cycle: inputs already set at the falling edge.
  task automatic cycle();
    logic [15:0] e;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_acc       = in_valid && in_ready;
    s_emit      = out_valid && out_ready;
    if (rst) begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      if (s_emit) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: data=%h with nothing expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %h required %h", out_data, e);
          end
        end
      end
      if (s_acc) exp_q.push_back(cur_exp);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < budget) begin
      cycle();
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; in_dec = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h in_ready=%b required 0/0000/0", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", s_in_ready);
    end
  endtask

  task automatic test_latency(input logic [15:0] x, input logic [4:0] key, input logic dec,
                              input logic [15:0] exp);
    int lat;
    in_valid = 1'b1; in_data = x; in_key = key; in_dec = dec; cur_exp = exp; out_ready = 1'b1;
    cycle();
    checks++;
    if (s_acc !== 1'b1) begin
      errors++;
      $display("FAIL latency_accept: accepted=%b required 1", s_acc);
    end
    in_valid = 1'b0;
    lat = 0;
    s_out_valid = 1'b0;
    while (!s_out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency: %0d cycles required 3", lat);
    end
    drain(10);
  endtask

  task automatic test_roundtrip();
    logic [15:0] xs [8];
    logic [15:0] ct [8];
    int          nc, g, ne, first, last;
    xs = '{16'h0000, 16'h0001, 16'hFFFF, 16'h1234, 16'hA5A5, 16'h8000, 16'h7FFE, 16'hBEEF};
    out_ready = 1'b1; in_key = 5'h15; nc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_dec = 1'b0; in_data = xs[i];
      cur_exp  = model(xs[i], 5'h15, 1'b0);
      cycle();
      checks++;
      if (!s_acc) begin
        errors++;
        $display("FAIL rt_enc_accept: beat %0d not accepted", i);
      end
      if (s_emit && nc < 8) begin ct[nc] = s_out_data; nc++; end
    end
    in_valid = 1'b0; g = 0;
    while (nc < 8 && g < 20) begin
      cycle();
      g++;
      if (s_emit) begin ct[nc] = s_out_data; nc++; end
    end
    checks++;
    if (nc != 8) begin
      errors++;
      $display("FAIL rt_enc_count: %0d beats required 8", nc);
    end
    // Mixed directions: decrypting a ciphertext must give back the plaintext.
    ne = 0; first = -1; last = -1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_dec   = (i % 2 == 0);
      in_data  = in_dec ? ct[i] : xs[i];
      cur_exp  = in_dec ? xs[i] : ct[i];
      cycle();
      if (s_emit) begin if (first < 0) first = cyc; last = cyc; ne++; end
    end
    in_valid = 1'b0; g = 0;
    while (ne < 8 && g < 20) begin
      cycle();
      g++;
      if (s_emit) begin if (first < 0) first = cyc; last = cyc; ne++; end
    end
    checks++;
    if (ne != 8 || last - first != 7) begin
      errors++;
      $display("FAIL rt_rate: %0d beats over span %0d required 8 over 7", ne, last - first);
    end
    drain(10);
  endtask

  task automatic test_backpressure();
    logic [15:0] xs [5];
    int          idx, g, base_out;
    xs = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A};
    in_key = 5'h03; idx = 0; base_out = n_out;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      in_dec   = (idx % 2 == 1);
      in_data  = xs[idx % 5];
      cur_exp  = model(xs[idx % 5], 5'h03, (idx % 2 == 1));
      cycle();
      if (s_acc) idx++;
    end
    checks++;
    if (idx != 3 || s_in_ready !== 1'b0 || s_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_capacity: accepted=%0d in_ready=%b out_valid=%b required 3/0/1", idx, s_in_ready, s_out_valid);
    end
    out_ready = 1'b1; g = 0;
    while (idx < 5 && g < 20) begin
      in_valid = 1'b1;
      in_dec   = (idx % 2 == 1);
      in_data  = xs[idx];
      cur_exp  = model(xs[idx], 5'h03, (idx % 2 == 1));
      cycle();
      g++;
      if (s_acc) idx++;
    end
    drain(10);
    checks++;
    if (n_out - base_out != 5) begin
      errors++;
      $display("FAIL bp_count: %0d beats out required 5", n_out - base_out);
    end
  endtask

  task automatic test_toggle();
    int idx, c, bubbles;
    logic [15:0] x;
    logic [4:0]  kk;
    idx = 0; c = 0; bubbles = 0;
    while (idx < 12 && c < 60) begin
      x  = 16'(16'h1000 + idx * 273);
      kk = 5'(idx * 7);
      in_valid  = 1'b1; in_data = x; in_key = kk; in_dec = 1'b0;
      cur_exp   = model(x, kk, 1'b0);
      out_ready = (c % 2 == 0);
      cycle();
      if (c >= 3 && !s_out_valid) bubbles++;
      if (s_acc) idx++;
      c++;
    end
    checks++;
    if (idx != 12 || bubbles != 0) begin
      errors++;
      $display("FAIL toggle: accepted=%0d bubbles=%0d required 12/0", idx, bubbles);
    end
    drain(20);
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1; in_key = 5'h0A; in_dec = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h4000 + i);
      cur_exp  = model(16'(16'h4000 + i), 5'h0A, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: valid=%b data=%h in_ready=%b required 0/0000/0", out_valid, out_data, in_ready);
    end
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle();
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: in_ready=%b required 1", s_in_ready);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (s_out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_ghost: %0d valid cycles required 0", seen);
    end
    test_latency(16'h0000, 5'h00, 1'b0, 16'h0013);
  endtask

`ifdef CRYPTO_STATS_EN
  task automatic feed(input int n);
    int idx, g;
    idx = 0; g = 0; out_ready = 1'b1; in_key = 5'h00; in_dec = 1'b0;
    while (idx < n && g < n + 100) begin
      in_valid = 1'b1; in_data = 16'(idx);
      cur_exp  = model(16'(idx), 5'h00, 1'b0);
      cycle();
      g++;
      if (s_acc) idx++;
    end
    drain(10);
  endtask

  task automatic test_stats();
    int idx, c;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    idx = 0; c = 0;
    in_key = 5'h00; in_dec = 1'b0;
    while (idx < 10 && c < 60) begin
      in_valid  = 1'b1; in_data = 16'(idx);
      cur_exp   = model(16'(idx), 5'h00, 1'b0);
      out_ready = !(c >= 5 && c <= 8);
      cycle();
      if (s_acc) idx++;
      c++;
    end
    drain(10);
    checks++;
    if (stat_beats !== 16'd10 || stat_stall !== 16'd4) begin
      errors++;
      $display("FAIL stats_count: beats=%0d stall=%0d required 10/4", stat_beats, stat_stall);
    end
    feed(65525);
    checks++;
    if (stat_beats !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_preload: beats=%h required ffff", stat_beats);
    end
    feed(1);
    checks++;
    if (stat_beats !== 16'h0000) begin
      errors++;
      $display("FAIL stats_wrap: beats=%h required 0000", stat_beats);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency(16'h0001, 5'h00, 1'b0, 16'h001B);
    test_latency(16'h001B, 5'h00, 1'b1, 16'h0001);
    test_latency(16'h0000, 5'h00, 1'b0, 16'h0013);
    test_roundtrip();
    test_backpressure();
    test_toggle();
    test_reset_mid();
`ifdef CRYPTO_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
